// File: rtl/qar_mem_arbiter.sv
// Two-master (fetch/data) to one-slave memory arbiter with bounded data priority
// and a slave-wait watchdog that aborts stalled transactions with an error response.
module qar_mem_arbiter #(
  parameter int          DATA_BURST_MAX = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic [1:0]  grant_id,
  output logic        bus_err
);

  localparam int BW = $clog2(DATA_BURST_MAX + 1);
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(DATA_BURST_MAX);
  localparam logic [WW-1:0] WD_LAST   = (TIMEOUT_CYCLES > 0) ? WW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, ABORT} state_t;

  state_t          state, state_nxt;
  logic            owner_d;
  logic [BW-1:0]   burst_cnt;
  logic [WW-1:0]   wd_cnt;
  logic            wd_expire;

  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    bus_err   = 1'b0;
    grant_id  = 2'b00;
    case (state)
      IDLE: begin
        if (d_valid && (!i_valid || burst_cnt != BURST_MAX)) state_nxt = GRANT_D;
        else if (i_valid)                                     state_nxt = GRANT_I;
      end
      GRANT_I: begin
        grant_id = 2'b01;
        if (m_ready) begin
          i_ready   = i_valid;
          i_rdata   = i_valid ? m_rdata : '0;
          state_nxt = IDLE;
        end else if (wd_expire) begin
          state_nxt = ABORT;
        end
      end
      GRANT_D: begin
        grant_id = 2'b10;
        if (m_ready) begin
          d_ready   = d_valid;
          d_rdata   = d_valid ? m_rdata : '0;
          state_nxt = IDLE;
        end else if (wd_expire) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        bus_err   = 1'b1;
        state_nxt = IDLE;
        if (owner_d) begin
          grant_id = 2'b10;
          d_ready  = d_valid;
          d_rdata  = d_valid ? ERR_RDATA : '0;
        end else begin
          grant_id = 2'b01;
          i_ready  = i_valid;
          i_rdata  = i_valid ? ERR_RDATA : '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      m_valid   <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      owner_d   <= 1'b0;
      burst_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (state_nxt == GRANT_D) begin
            m_valid <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            owner_d <= 1'b1;
            wd_cnt  <= '0;
            // only data grants that jump ahead of a waiting fetch count toward the burst
            if (!i_valid)                    burst_cnt <= '0;
            else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
          end else if (state_nxt == GRANT_I) begin
            m_valid   <= 1'b1;
            m_we      <= 1'b0;
            m_addr    <= i_addr;
            m_wdata   <= '0;
            owner_d   <= 1'b0;
            wd_cnt    <= '0;
            burst_cnt <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (state_nxt != state) m_valid <= 1'b0;
          else                    wd_cnt  <= wd_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
